// File: rtl/pipe_issue_pkg.sv
// Shared instruction format and opcode constants for the issue stage and
// the execute pipeline.
package pipe_issue_pkg;
  localparam int REG_W   = 4;
  localparam int FUNC_W  = 4;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = FUNC_W + 3*REG_W + ADDR_W;

  localparam int FUNC_LSB = 20;
  localparam int RD_LSB   = 16;
  localparam int RS1_LSB  = 12;
  localparam int RS2_LSB  = 8;
  localparam int ADDR_LSB = 0;

  typedef enum logic [FUNC_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_SLA = 4'd11
  } func_e;

  // Field order mirrors the bit positions above, MSB first.
  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [ADDR_W-1:0] addr;
  } instr_t;
endpackage

// File: rtl/issue_fifo.sv
// Instruction buffer: power-of-two FIFO with wrapping pointers and an
// occupancy counter; head is visible combinationally from storage.
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                         clk1,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  logic [W-1:0]                 i_din,
  output logic [W-1:0]                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PW-1:0]           r_wptr;
  logic [PW-1:0]           r_rptr;
  logic [CW-1:0]           r_count;
  logic                    w_push;
  logic                    w_pop;

  // Flush wins over both sides so a same-edge push is dropped.
  assign w_push  = i_push && (r_count != CW'(DEPTH)) && !i_flush;
  assign w_pop   = i_pop  && (r_count != '0)         && !i_flush;
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk1) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/pipe_issue.sv
// In-order issue stage: buffers instructions and holds the head while any of
// the last HAZ_WIN issue slots wrote one of its source registers.
module pipe_issue
  import pipe_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int HAZ_WIN = 2
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  input  logic               flush,
  output logic [REG_W-1:0]   rs1,
  output logic [REG_W-1:0]   rs2,
  output logic [REG_W-1:0]   rd,
  output logic [FUNC_W-1:0]  func,
  output logic [ADDR_W-1:0]  addr,
  output logic               out_valid,
  output logic [7:0]         stall_cnt
);
  localparam int CW = $clog2(DEPTH+1);

  instr_t                          w_head;
  logic [INSTR_W-1:0]              w_head_raw;
  logic [CW-1:0]                   w_count;
  logic                            w_empty;
  logic                            w_hazard;
  logic                            w_issue;
  logic [HAZ_WIN-1:0]              w_slot_hit;
  logic [HAZ_WIN-1:0]              r_sb_vld;
  logic [HAZ_WIN-1:0][REG_W-1:0]   r_sb_rd;

  issue_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .clk1    (clk1),
    .rst_n   (rst_n),
    .i_push  (in_valid),
    .i_pop   (w_issue),
    .i_flush (flush),
    .i_din   (in_instr),
    .o_head  (w_head_raw),
    .o_count (w_count)
  );

  assign w_head   = instr_t'(w_head_raw);
  assign w_empty  = (w_count == '0);
  assign in_ready = (w_count < CW'(DEPTH));

  for (genvar g = 0; g < HAZ_WIN; g++) begin : g_slot
    assign w_slot_hit[g] = r_sb_vld[g] &&
                           ((r_sb_rd[g] == w_head.rs1) || (r_sb_rd[g] == w_head.rs2));
  end

  assign w_hazard = |w_slot_hit;
  assign w_issue  = !w_empty && !w_hazard && !flush;

  // Slot 0 holds the newest issue; bubbles shift in as invalid tags.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_vld <= '0;
      r_sb_rd  <= '0;
    end else if (flush) begin
      r_sb_vld <= '0;
    end else begin
      r_sb_vld[0] <= w_issue;
      r_sb_rd[0]  <= w_head.rd;
      for (int i = 1; i < HAZ_WIN; i++) begin
        r_sb_vld[i] <= r_sb_vld[i-1];
        r_sb_rd[i]  <= r_sb_rd[i-1];
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      func      <= '0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      addr      <= '0;
    end else begin
      out_valid <= w_issue;
      if (w_issue) begin
        func <= w_head.func;
        rd   <= w_head.rd;
        rs1  <= w_head.rs1;
        rs2  <= w_head.rs2;
        addr <= w_head.addr;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!w_empty && !flush && w_hazard && (stall_cnt != 8'hFF)) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_pipe_issue.sv
// Bench for pipe_issue: directed scenarios plus random traffic, all compared
// against a queue-based reference model evaluated once per clock edge.
module tb_pipe_issue;
  import pipe_issue_pkg::*;

  localparam int DEPTH   = 4;
  localparam int HAZ_WIN = 2;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        in_valid;
  instr_t      in_instr;
  logic        in_ready;
  logic        flush;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic        out_valid;
  logic [7:0]  stall_cnt;

  pipe_issue #(.DEPTH(DEPTH), .HAZ_WIN(HAZ_WIN)) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .flush     (flush),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .func      (func),
    .addr      (addr),
    .out_valid (out_valid),
    .stall_cnt (stall_cnt)
  );

  always #5 clk1 = ~clk1;

  int     errors = 0;
  int     checks = 0;
  instr_t q[$];
  int     hist[$];
  int     exp_stall;
  logic   exp_ov;
  instr_t exp_out;
  logic   saw_full;
  int     iss_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    hist.delete();
    for (int i = 0; i < HAZ_WIN; i++) hist.push_back(-1);
    exp_stall = 0;
    exp_ov    = 1'b0;
    exp_out   = '0;
  endfunction

  // One clock edge of the rules: hazard if any of the last HAZ_WIN issued
  // destinations is read by the oldest buffered instruction.
  function automatic void model_edge(input logic v, input instr_t ins, input logic fl);
    bit ready = (q.size() < DEPTH);
    bit haz   = 0;
    bit issue;
    if (q.size() > 0)
      foreach (hist[i])
        if (hist[i] >= 0 && (hist[i] == int'(q[0].rs1) || hist[i] == int'(q[0].rs2))) haz = 1;
    if (fl) begin
      q.delete();
      foreach (hist[i]) hist[i] = -1;
      exp_ov = 1'b0;
      return;
    end
    issue = (q.size() > 0) && !haz;
    if (q.size() > 0 && haz && exp_stall < 255) exp_stall++;
    if (issue) exp_out = q.pop_front();
    exp_ov = issue;
    hist.push_front(issue ? int'(exp_out.rd) : -1);
    void'(hist.pop_back());
    if (v && ready) q.push_back(ins);
  endfunction

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("func",      32'(func),      32'(exp_out.func));
    chk("rd",        32'(rd),        32'(exp_out.rd));
    chk("rs1",       32'(rs1),       32'(exp_out.rs1));
    chk("rs2",       32'(rs2),       32'(exp_out.rs2));
    chk("addr",      32'(addr),      32'(exp_out.addr));
    chk("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
  endtask

  task automatic tick();
    model_edge(in_valid, in_instr, flush);
    @(posedge clk1);
    #1;
    check_all();
    iss_log.push_back(out_valid ? int'(rd) : -1);
  endtask

  task automatic push_hs(input instr_t ins);
    int budget;
    budget   = 40;
    in_valid = 1'b1;
    in_instr = ins;
    while (in_ready !== 1'b1 && budget > 0) begin
      saw_full = 1'b1;
      tick();
      budget--;
    end
    checks++;
    assert (budget > 0) else begin
      errors++;
      $error("FAIL push_timeout in_ready=%b required=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  function automatic instr_t mk(input int f, input int d, input int s1, input int s2, input int a);
    instr_t t;
    t.func = 4'(f); t.rd = 4'(d); t.rs1 = 4'(s1); t.rs2 = 4'(s2); t.addr = 8'(a);
    return t;
  endfunction

  initial begin
    int first, second;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    flush    = 1'b0;
    saw_full = 1'b0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // Single instruction latency and field routing.
    push_hs(mk(OP_ADD, 10, 3, 5, 125));
    tick();
    chk("r030_valid", 32'(out_valid), 32'd1);
    chk("r030_fields", {12'd0, func, rd, rs1, rs2, addr}, {12'd0, 4'd0, 4'd10, 4'd3, 4'd5, 8'd125});
    repeat (3) tick();

    // Dependent pair: exactly HAZ_WIN bubbles between producer and consumer.
    iss_log.delete();
    push_hs(mk(OP_ADD, 10, 3, 5, 1));
    push_hs(mk(OP_SUB, 14, 10, 5, 2));
    repeat (6) tick();
    first = -1; second = -1;
    foreach (iss_log[i])
      if (iss_log[i] >= 0) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    chk("r031_bubbles", 32'(second - first - 1), 32'(HAZ_WIN));
    chk("r031_stall", 32'(stall_cnt), 32'd2);

    // Dependency chain throttles issue so the buffer fills and refuses pushes.
    saw_full = 1'b0;
    push_hs(mk(OP_MUL, 1, 12, 13, 10));
    push_hs(mk(OP_MUL, 2, 1, 13, 11));
    push_hs(mk(OP_MUL, 3, 2, 13, 12));
    for (int k = 0; k < 5; k++) push_hs(mk(OP_SLA, 4 + k, 13, 12, 20 + k));
    repeat (12) tick();
    chk("r032_full_seen", 32'(saw_full), 32'd1);

    // Flush with a simultaneous push: everything buffered is discarded.
    push_hs(mk(OP_ADD, 1, 12, 13, 30));
    push_hs(mk(OP_ADD, 2, 1, 13, 31));
    push_hs(mk(OP_ADD, 3, 2, 13, 32));
    push_hs(mk(OP_ADD, 4, 3, 13, 33));
    in_valid = 1'b1; in_instr = mk(OP_SUB, 5, 12, 12, 34); flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("r033_occ", 32'(dut.u_fifo.o_count), 32'd0);
    chk("r033_valid", 32'(out_valid), 32'd0);
    repeat (5) tick();

    // Asynchronous reset between edges with entries buffered.
    push_hs(mk(OP_MUL, 6, 12, 13, 40));
    push_hs(mk(OP_MUL, 7, 6, 13, 41));
    push_hs(mk(OP_MUL, 8, 7, 13, 42));
    push_hs(mk(OP_MUL, 9, 13, 12, 43));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("r034_occ", 32'(dut.u_fifo.o_count), 32'd0);
    #1 rst_n = 1'b1;
    repeat (4) tick();

    // Random traffic with a small register pool to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = mk($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 255));
      flush    = ($urandom_range(0, 29) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;
    repeat (8) tick();

    // Alternating dependent pairs drive the stall counter into saturation.
    for (int p = 0; p < 300; p++) begin
      push_hs(mk(OP_ADD, p % 8, 12, 13, p));
      push_hs(mk(OP_SUB, 8 + (p % 4), p % 8, p % 8, p + 1));
    end
    repeat (10) tick();
    chk("r035_sat", 32'(stall_cnt), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
